// File: rtl/edge_event_pkg.sv
// edge_event_pkg
// Shared definitions for the edge event unit:
//   - edge_mode field encodings (one 2-bit field per channel)
//   - warm-up state encoding
//   - helpers that size the per-channel pulse-stretch counter
// Optional feature macro used by the unit: EDGE_EVENT_FILTER_EN.
package edge_event_pkg;

  localparam logic [1:0] EDGE_OFF  = 2'b00;
  localparam logic [1:0] EDGE_RISE = 2'b01;
  localparam logic [1:0] EDGE_FALL = 2'b10;
  localparam logic [1:0] EDGE_BOTH = 2'b11;

  typedef enum logic {
    WARM = 1'b0,
    RUN  = 1'b1
  } warm_state_e;

  // PULSE_EXT of 0 or 1 both mean a single-cycle pulse.
  function automatic int stretch_len(input int pulse_ext);
    return (pulse_ext < 1) ? 1 : pulse_ext;
  endfunction

  function automatic int stretch_cnt_w(input int pulse_ext);
    return $clog2(stretch_len(pulse_ext) + 1);
  endfunction

endpackage

// File: rtl/edge_event_chan.sv
// edge_event_chan
// One edge-detect channel: synchroniser, optional glitch filter,
// previous-sample register, edge compare, pulse-stretch counter and
// sticky pending flag.
// Optional feature macro: EDGE_EVENT_FILTER_EN (inserts the glitch filter
// and the FILTER_LEN parameter).
// Ports:
//   clk, reset_qual_n : clock, async active-low reset
//   run_i             : edge detection enabled (warm-up finished)
//   signal_i          : raw asynchronous input
//   mode_i            : 00 off, 01 rising, 10 falling, 11 both
//   clr_i             : write-one-to-clear for the pending flag
//   pulse_o           : stretched edge pulse
//   pend_o            : sticky edge-seen flag
module edge_event_chan
  import edge_event_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int PULSE_EXT   = 1
`ifdef EDGE_EVENT_FILTER_EN
  , parameter int FILTER_LEN = 3
`endif
) (
  input  logic       clk,
  input  logic       reset_qual_n,
  input  logic       run_i,
  input  logic       signal_i,
  input  logic [1:0] mode_i,
  input  logic       clr_i,
  output logic       pulse_o,
  output logic       pend_o
);

  localparam int PLEN = stretch_len(PULSE_EXT);
  localparam int CW   = stretch_cnt_w(PULSE_EXT);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   samp;
  logic                   prev_q;
  logic                   det;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   pend_q, pend_d;

  always_ff @(posedge clk or negedge reset_qual_n) begin
    if (!reset_qual_n) sync_q <= '0;
    else               sync_q <= {sync_q[SYNC_STAGES-2:0], signal_i};
  end

`ifdef EDGE_EVENT_FILTER_EN
  // The filtered level only moves after FILTER_LEN consecutive synchronised
  // samples that all disagree with it; any agreeing sample restarts the count.
  logic       filt_q;
  logic [3:0] fcnt_q;

  always_ff @(posedge clk or negedge reset_qual_n) begin
    if (!reset_qual_n) begin
      filt_q <= 1'b0;
      fcnt_q <= '0;
    end else if (sync_q[SYNC_STAGES-1] == filt_q) begin
      fcnt_q <= '0;
    end else if (fcnt_q == 4'(FILTER_LEN - 1)) begin
      filt_q <= sync_q[SYNC_STAGES-1];
      fcnt_q <= '0;
    end else begin
      fcnt_q <= fcnt_q + 4'd1;
    end
  end

  assign samp = filt_q;
`else
  assign samp = sync_q[SYNC_STAGES-1];
`endif

  // prev_q tracks the input even when the channel is off or warming up, so
  // enabling a mode never turns an old level difference into an edge.
  always_comb begin
    det = 1'b0;
    case (mode_i)
      EDGE_OFF:  det = 1'b0;
      EDGE_RISE: det = samp & ~prev_q;
      EDGE_FALL: det = ~samp & prev_q;
      EDGE_BOTH: det = samp ^ prev_q;
      default:   det = 1'b0;
    endcase
    det = det & run_i;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (det)               cnt_d = CW'(PLEN);
    else if (cnt_q != '0)  cnt_d = cnt_q - CW'(1);
  end

  // A new edge wins over a simultaneous clear.
  always_comb begin
    pend_d = pend_q;
    if (det)        pend_d = 1'b1;
    else if (clr_i) pend_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_qual_n) begin
    if (!reset_qual_n) begin
      prev_q <= 1'b0;
      cnt_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      prev_q <= samp;
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
    end
  end

  assign pulse_o = (cnt_q != '0);
  assign pend_o  = pend_q;

endmodule

// File: rtl/edge_event_unit.sv
// edge_event_unit
// Multi-channel edge detector with synchronisers, pulse stretch, sticky
// pending flags and a combined interrupt.
// Optional feature macro: EDGE_EVENT_FILTER_EN (per-channel glitch filter,
// FILTER_LEN cycles of stability; also lengthens the warm-up).
// Ports:
//   clk, reset_qual_n : clock, async active-low reset
//   signal_in         : raw asynchronous inputs, one per channel
//   edge_mode         : 2 bits per channel, [2i+1:2i]
//   event_clr         : write-one-to-clear strobes for event_pend
//   pulse_out         : stretched edge pulses
//   event_pend        : sticky edge-seen flags
//   irq               : registered OR of event_pend
//
// Warm-up FSM
//   state | meaning
//   WARM  | after reset release; edge detection suppressed while pipeline fills
//   RUN   | edge detection enabled; left only by reset
module edge_event_unit
  import edge_event_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int PULSE_EXT   = 1,
  parameter int FILTER_LEN  = 3
) (
  input  logic                  clk,
  input  logic                  reset_qual_n,
  input  logic [NUM_CH-1:0]     signal_in,
  input  logic [2*NUM_CH-1:0]   edge_mode,
  input  logic [NUM_CH-1:0]     event_clr,
  output logic [NUM_CH-1:0]     pulse_out,
  output logic [NUM_CH-1:0]     event_pend,
  output logic                  irq
);

`ifdef EDGE_EVENT_FILTER_EN
  localparam int FILT_CYC = FILTER_LEN;
`else
  // No filter in this build, so FILTER_LEN adds nothing to the warm-up.
  localparam int FILT_CYC = 0 * FILTER_LEN;
`endif

  // Covers the reset-value sample travelling through the synchroniser (and
  // filter) into the previous-sample register.
  localparam int WARM_CYC = SYNC_STAGES + 1 + FILT_CYC;
  localparam int WW       = $clog2(WARM_CYC + 1);

  warm_state_e   state_q;
  logic [WW-1:0] wcnt_q;
  logic          run;
  logic          irq_q;

  always_ff @(posedge clk or negedge reset_qual_n) begin
    if (!reset_qual_n) begin
      state_q <= WARM;
      wcnt_q  <= '0;
    end else begin
      case (state_q)
        WARM: begin
          if (wcnt_q == WW'(WARM_CYC - 1)) state_q <= RUN;
          else                             wcnt_q  <= wcnt_q + WW'(1);
        end
        RUN:     state_q <= RUN;
        default: state_q <= WARM;
      endcase
    end
  end

  assign run = (state_q == RUN);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    edge_event_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .PULSE_EXT   (PULSE_EXT)
`ifdef EDGE_EVENT_FILTER_EN
      , .FILTER_LEN (FILTER_LEN)
`endif
    ) u_chan (
      .clk          (clk),
      .reset_qual_n (reset_qual_n),
      .run_i        (run),
      .signal_i     (signal_in[i]),
      .mode_i       (edge_mode[2*i+1:2*i]),
      .clr_i        (event_clr[i]),
      .pulse_o      (pulse_out[i]),
      .pend_o       (event_pend[i])
    );
  end

  always_ff @(posedge clk or negedge reset_qual_n) begin
    if (!reset_qual_n) irq_q <= 1'b0;
    else               irq_q <= |event_pend;
  end

  assign irq = irq_q;

endmodule

// File: tb/tb_edge_event_unit.sv
module tb_edge_event_unit;

  localparam int NUM_CH = 4;
  localparam int SYNC   = 2;
  localparam int PEXT   = 4;
  localparam int FLEN   = 3;
`ifdef EDGE_EVENT_FILTER_EN
  localparam int LAT = SYNC + FLEN;
`else
  localparam int LAT = SYNC;
`endif

  typedef struct packed {
    logic [3:0] pulse;
    logic [3:0] pend;
    logic       irq;
  } obs_t;

  logic                clk = 1'b0;
  logic                reset_qual_n;
  logic [NUM_CH-1:0]   signal_in;
  logic [2*NUM_CH-1:0] edge_mode;
  logic [NUM_CH-1:0]   event_clr;
  logic [NUM_CH-1:0]   pulse_out;
  logic [NUM_CH-1:0]   event_pend;
  logic                irq;

  obs_t sb[$];
  int   tests = 0;
  int   fails = 0;

  edge_event_unit #(
    .NUM_CH      (NUM_CH),
    .SYNC_STAGES (SYNC),
    .PULSE_EXT   (PEXT),
    .FILTER_LEN  (FLEN)
  ) dut (
    .clk          (clk),
    .reset_qual_n (reset_qual_n),
    .signal_in    (signal_in),
    .edge_mode    (edge_mode),
    .event_clr    (event_clr),
    .pulse_out    (pulse_out),
    .event_pend   (event_pend),
    .irq          (irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] p, input logic [3:0] e, input logic q);
    obs_t o;
    o.pulse = p;
    o.pend  = e;
    o.irq   = q;
    sb.push_back(o);
  endtask

  task automatic test_reset();
    obs_t exp;
    reset_qual_n = 1'b0;
    signal_in    = 4'b1111;
    edge_mode    = 8'hFF;
    event_clr    = '0;
    tick();
    tick();
    tests++;
    if ({pulse_out, event_pend, irq} !== 9'd0) begin
      fails++;
      $display("FAIL reset_hold got pulse=%b pend=%b irq=%b exp all 0", pulse_out, event_pend, irq);
    end
    for (int k = 0; k < 12 + LAT; k++) push(4'b0000, 4'b0000, 1'b0);
    reset_qual_n = 1'b1;
    for (int k = 0; k < 12 + LAT; k++) begin
      tick();
      exp = sb.pop_front();
      tests++;
      if ({pulse_out, event_pend, irq} !== exp) begin
        fails++;
        $display("FAIL warmup k=%0d got pulse=%b pend=%b irq=%b exp pulse=%b pend=%b irq=%b",
                 k, pulse_out, event_pend, irq, exp.pulse, exp.pend, exp.irq);
      end
    end
  endtask

  task automatic test_rise();
    obs_t exp;
    edge_mode = 8'h00;
    signal_in = 4'b0000;
    repeat (LAT + 4) tick();
    edge_mode = 8'h01;
    for (int k = 0; k < LAT + 8; k++)
      push((k >= LAT && k < LAT + PEXT) ? 4'b0001 : 4'b0000,
           (k >= LAT) ? 4'b0001 : 4'b0000, k >= LAT + 1);
    for (int k = 0; k < LAT + 8; k++) begin
      if (k == 0) signal_in[0] = 1'b1;
      tick();
      exp = sb.pop_front();
      tests++;
      if ({pulse_out, event_pend, irq} !== exp) begin
        fails++;
        $display("FAIL rise k=%0d got pulse=%b pend=%b irq=%b exp pulse=%b pend=%b irq=%b",
                 k, pulse_out, event_pend, irq, exp.pulse, exp.pend, exp.irq);
      end
    end
  endtask

  task automatic test_retrigger();
    obs_t exp;
    edge_mode = 8'h09;
    signal_in[1] = 1'b1;
    repeat (LAT + 2) tick();
    for (int k = 0; k < LAT + 10; k++)
      push((k >= LAT && k < LAT + 2 + PEXT) ? 4'b0010 : 4'b0000,
           (k >= LAT) ? 4'b0011 : 4'b0001, 1'b1);
    for (int k = 0; k < LAT + 10; k++) begin
      if (k == 0) signal_in[1] = 1'b0;
      if (k == 1) signal_in[1] = 1'b1;
      if (k == 2) signal_in[1] = 1'b0;
      tick();
      exp = sb.pop_front();
      tests++;
      if ({pulse_out, event_pend, irq} !== exp) begin
        fails++;
        $display("FAIL retrigger k=%0d got pulse=%b pend=%b irq=%b exp pulse=%b pend=%b irq=%b",
                 k, pulse_out, event_pend, irq, exp.pulse, exp.pend, exp.irq);
      end
    end
  endtask

  task automatic test_clr_collision();
    obs_t exp;
    signal_in[0] = 1'b0;
    repeat (LAT + 2) tick();
    for (int k = 0; k < LAT + 6; k++)
      push((k >= LAT && k < LAT + PEXT) ? 4'b0001 : 4'b0000,
           (k <= LAT) ? 4'b0011 : 4'b0000, k <= LAT + 1);
    for (int k = 0; k < LAT + 6; k++) begin
      if (k == 0) signal_in[0] = 1'b1;
      event_clr = (k == LAT) ? 4'b0001 : (k == LAT + 1) ? 4'b0011 : 4'b0000;
      tick();
      exp = sb.pop_front();
      tests++;
      if ({pulse_out, event_pend, irq} !== exp) begin
        fails++;
        $display("FAIL clr_collision k=%0d got pulse=%b pend=%b irq=%b exp pulse=%b pend=%b irq=%b",
                 k, pulse_out, event_pend, irq, exp.pulse, exp.pend, exp.irq);
      end
    end
    event_clr = '0;
  endtask

  task automatic test_both_off();
    obs_t exp;
    edge_mode = 8'h39;
    for (int k = 0; k < LAT + 11; k++)
      push(((k >= LAT && k < LAT + PEXT) || (k >= LAT + 5 && k < LAT + 5 + PEXT)) ? 4'b0100 : 4'b0000,
           (k >= LAT) ? 4'b0100 : 4'b0000, k >= LAT + 1);
    for (int k = 0; k < LAT + 11; k++) begin
      if (k == 0) signal_in[3:2] = 2'b11;
      if (k == 5) signal_in[3:2] = 2'b00;
      tick();
      exp = sb.pop_front();
      tests++;
      if ({pulse_out, event_pend, irq} !== exp) begin
        fails++;
        $display("FAIL both_off k=%0d got pulse=%b pend=%b irq=%b exp pulse=%b pend=%b irq=%b",
                 k, pulse_out, event_pend, irq, exp.pulse, exp.pend, exp.irq);
      end
    end
  endtask

  task automatic test_mode_change();
    obs_t exp;
    signal_in[3] = 1'b1;
    repeat (LAT + 2) tick();
    edge_mode = 8'hF9;
    for (int k = 0; k < LAT + 9; k++)
      push((k >= LAT + 3 && k < LAT + 3 + PEXT) ? 4'b1000 : 4'b0000,
           (k >= LAT + 3) ? 4'b1100 : 4'b0100, 1'b1);
    for (int k = 0; k < LAT + 9; k++) begin
      if (k == 3) signal_in[3] = 1'b0;
      tick();
      exp = sb.pop_front();
      tests++;
      if ({pulse_out, event_pend, irq} !== exp) begin
        fails++;
        $display("FAIL mode_change k=%0d got pulse=%b pend=%b irq=%b exp pulse=%b pend=%b irq=%b",
                 k, pulse_out, event_pend, irq, exp.pulse, exp.pend, exp.irq);
      end
    end
  endtask

  task automatic test_reset_mid_pulse();
    obs_t exp;
    edge_mode = 8'hFB;
    event_clr = 4'b1111;
    tick();
    event_clr = '0;
    tick();
    tick();
    for (int k = 0; k < LAT + 2; k++)
      push((k >= LAT) ? 4'b0001 : 4'b0000, (k >= LAT) ? 4'b0001 : 4'b0000, k >= LAT + 1);
    for (int k = 0; k < LAT + 2; k++) begin
      if (k == 0) signal_in[0] = 1'b0;
      tick();
      exp = sb.pop_front();
      tests++;
      if ({pulse_out, event_pend, irq} !== exp) begin
        fails++;
        $display("FAIL pre_reset k=%0d got pulse=%b pend=%b irq=%b exp pulse=%b pend=%b irq=%b",
                 k, pulse_out, event_pend, irq, exp.pulse, exp.pend, exp.irq);
      end
    end
    #2;
    reset_qual_n = 1'b0;
    #1;
    tests++;
    if ({pulse_out, event_pend, irq} !== 9'd0) begin
      fails++;
      $display("FAIL async_reset got pulse=%b pend=%b irq=%b exp all 0", pulse_out, event_pend, irq);
    end
    tick();
    tick();
    reset_qual_n = 1'b1;
    signal_in[0] = 1'b1;
    for (int k = 0; k < LAT + 5; k++) push(4'b0000, 4'b0000, 1'b0);
    for (int k = 0; k < LAT + 5; k++) begin
      tick();
      exp = sb.pop_front();
      tests++;
      if ({pulse_out, event_pend, irq} !== exp) begin
        fails++;
        $display("FAIL rewarm k=%0d got pulse=%b pend=%b irq=%b exp pulse=%b pend=%b irq=%b",
                 k, pulse_out, event_pend, irq, exp.pulse, exp.pend, exp.irq);
      end
    end
    for (int k = 0; k < LAT + 6; k++)
      push((k >= LAT && k < LAT + PEXT) ? 4'b0001 : 4'b0000,
           (k >= LAT) ? 4'b0001 : 4'b0000, k >= LAT + 1);
    for (int k = 0; k < LAT + 6; k++) begin
      if (k == 0) signal_in[0] = 1'b0;
      tick();
      exp = sb.pop_front();
      tests++;
      if ({pulse_out, event_pend, irq} !== exp) begin
        fails++;
        $display("FAIL post_warm k=%0d got pulse=%b pend=%b irq=%b exp pulse=%b pend=%b irq=%b",
                 k, pulse_out, event_pend, irq, exp.pulse, exp.pend, exp.irq);
      end
    end
  endtask

`ifdef EDGE_EVENT_FILTER_EN
  task automatic test_filter();
    obs_t exp;
    edge_mode = 8'h01;
    signal_in = 4'b0000;
    repeat (LAT + 6) tick();
    event_clr = 4'b1111;
    tick();
    event_clr = '0;
    tick();
    tick();
    for (int k = 0; k < 26; k++)
      push((k >= 10 + LAT && k < 10 + LAT + PEXT) ? 4'b0001 : 4'b0000,
           (k >= 10 + LAT) ? 4'b0001 : 4'b0000, k >= 11 + LAT);
    for (int k = 0; k < 26; k++) begin
      if (k == 0)  signal_in[0] = 1'b1;
      if (k == 2)  signal_in[0] = 1'b0;
      if (k == 10) signal_in[0] = 1'b1;
      if (k == 13) signal_in[0] = 1'b0;
      tick();
      exp = sb.pop_front();
      tests++;
      if ({pulse_out, event_pend, irq} !== exp) begin
        fails++;
        $display("FAIL filter k=%0d got pulse=%b pend=%b irq=%b exp pulse=%b pend=%b irq=%b",
                 k, pulse_out, event_pend, irq, exp.pulse, exp.pend, exp.irq);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_rise();
    test_retrigger();
    test_clr_collision();
    test_both_off();
    test_mode_change();
    test_reset_mid_pulse();
`ifdef EDGE_EVENT_FILTER_EN
    test_filter();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired tests=%0d", tests);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/edge_event_unit.md
# edge_event_unit

Multi-channel, run-time configurable edge detector with input synchronisation, programmable pulse stretch, sticky event flags and a combined interrupt. It sits between asynchronous fabric/PS GPIO-style inputs and the control/status register block. Each channel detects rising, falling or both edges and produces a stretched pulse. Each edge also sets a pending flag that software clears.

## Interface
Parameters:
- NUM_CH, 4: number of independent channels (1..32).
- SYNC_STAGES, 2: synchroniser flops per channel (2..4).
- PULSE_EXT, 1: pulse_out high time in clk cycles. Values 0 and 1 both give a single-cycle pulse.
- FILTER_LEN, 3: glitch-filter stability length in cycles (1..15). Used only when the filter is compiled in.

Ports:
- clk, in, 1: clock.
- reset_qual_n, in, 1: reset, asynchronous, active-low.
- signal_in, in, NUM_CH: raw asynchronous inputs.
- edge_mode, in, 2*NUM_CH: per channel [2i+1:2i]. 00 = off, 01 = rising, 10 = falling, 11 = both.
- event_clr, in, NUM_CH: write-one-to-clear strobe for event_pend, one cycle.
- pulse_out, out, NUM_CH: stretched edge pulse per channel.
- event_pend, out, NUM_CH: sticky edge-seen flag per channel.
- irq, out, 1: registered OR of event_pend.

## Operation
- Reset values: pulse_out = 0, event_pend = 0, irq = 0. Synchroniser flops, previous-sample register, stretch counters and warm-up counter are all 0.
- Per-channel pipeline: synchroniser → optional filter → previous-sample register → edge compare → stretch counter.
- Warm-up: a shared counter suppresses all edge detection for SYNC_STAGES+1 cycles after reset release, plus FILTER_LEN cycles when the filter is present. This prevents a false edge from the reset-value sample. Warm-up states are WARM and RUN. WARM goes to RUN when the count expires. RUN is left only by reset.
- Edge found in RUN: the stretch counter loads max(PULSE_EXT,1). pulse_out = (counter != 0). The counter decrements each cycle down to 0.
- Retrigger: an edge while the counter is nonzero reloads it to full length, so the pulse extends. No gap and no double pulse.
- Mode 11 detects both polarities. Mode 00 blocks pulse and pend, but the previous-sample register keeps updating.
- A mode change takes effect on the next compare. It never creates an edge by itself.
- event_pend[i] is set on any enabled edge and cleared by event_clr[i]. If set and clear happen in the same cycle, set wins and the flag stays 1.
- irq is updated one cycle after event_pend.
- Counter width is $clog2(max(PULSE_EXT,1)+1). The counter saturates at 0 and has no wrap-around.
- Asserting reset mid-pulse clears everything immediately (asynchronous). Warm-up restarts on release.

## Timing
- Input change captured by the first synchroniser flop at edge 0 (filter disabled): pulse_out and event_pend rise after edge SYNC_STAGES.
- pulse_out stays high for exactly max(PULSE_EXT,1) cycles, unless retriggered.
- irq rises one cycle after event_pend.
- With the filter enabled, all of the above shift by FILTER_LEN cycles.
- event_clr acts at the next clock edge. event_pend reads 0 one cycle after the strobe.
- Inputs must be stable for at least one cycle on each level to be seen. Faster toggles are undefined without the filter.

## Configuration
- Macro: EDGE_EVENT_FILTER_EN.
- Defined: a per-channel glitch filter is inserted after the synchroniser. The filtered value changes only after FILTER_LEN consecutive identical synchronised samples that differ from the current value. Shorter pulses are dropped. Latency grows by FILTER_LEN cycles.
- Undefined: the synchroniser output feeds edge detection directly. FILTER_LEN is ignored and no filter logic exists.

## Structure
- Package edge_event_pkg holds:
  - the edge_mode encodings (EDGE_OFF, EDGE_RISE, EDGE_FALL, EDGE_BOTH);
  - the warm-up state encoding (WARM, RUN);
  - a function returning the stretch-counter width.
- Sub-module edge_event_chan holds one channel: synchroniser, filter, previous sample, compare, stretch counter and pend flag. The top level instantiates it NUM_CH times with a generate loop and holds the shared warm-up counter and the irq register.

## Test plan
- Reset release with signal_in = 4'b1111 held, all modes 11 → no pulse_out, event_pend = 0 through warm-up and after.
- Ch0 mode 01, PULSE_EXT = 4, 0→1 on signal_in[0] → pulse_out[0] high 4 cycles starting SYNC_STAGES edges later; event_pend = 4'b0001; irq = 1 one cycle after.
- Ch1 mode 10, second falling edge 2 cycles into a PULSE_EXT = 4 pulse → pulse_out[1] stays high for 6 cycles in total.
- event_clr[0] in the same cycle as a new ch0 edge → event_pend[0] stays 1. A clear one cycle later → 0, and irq drops the following cycle.
- Filter build, FILTER_LEN = 3: 2-cycle high glitch → no pulse. 3-cycle high → one pulse.
- reset_qual_n asserted mid-pulse → pulse_out, event_pend and irq go to 0 immediately. Edges are ignored until warm-up completes.
